// File: rtl/ball_link_pkg.sv
// ball_link_pkg: shared types and default timing constants for the ball_link
// single-wire ball-handoff transceiver.
//   tx_state_t - TX pulse generator states
//   rx_state_t - RX width qualifier states
//   *_DEF      - default tick counts for the top-level parameters
package ball_link_pkg;

    localparam int TX_LEN_DEF = 4;  // ticks the line is pulled low per send
    localparam int GUARD_DEF  = 2;  // ticks RX stays blanked after TX release
    localparam int RX_MIN_DEF = 2;  // shortest low width accepted as a ball
    localparam int RX_MAX_DEF = 8;  // longest low width before "stuck line"

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_DRIVE   = 2'd1,
        TX_RECOVER = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_LOW   = 2'd1,
        RX_STUCK = 2'd2
    } rx_state_t;

endpackage

// File: rtl/ball_link_if.sv
// ball_link_if: signal bundle between the game FSM and the ball_link
// transceiver (plus the raw line level from the board tristate).
//   tick      - timebase enable, one clk wide
//   send      - request to pass the ball, one clk wide
//   line_in   - raw, asynchronous line level (idle high)
//   line_oe   - 1 = pull the shared line low
//   tx_busy   - transmitter not idle
//   rx_strobe - one-clk valid ball arrival
//   rx_err    - one-clk stuck-line indication
//   collision - one-clk rejected send (0 unless collision checking is built in)
//
// Handshake: there is no valid/ready back-pressure here. send is a single-clk
// request that is taken only when tx_busy is 0 (and, with collision checking,
// the line is idle); otherwise it is dropped, never queued. rx_strobe, rx_err
// and collision are single-clk notifications the consumer must catch in that
// cycle.
interface ball_link_if;
    logic tick;
    logic send;
    logic line_in;
    logic line_oe;
    logic tx_busy;
    logic rx_strobe;
    logic rx_err;
    logic collision;

    // Game side / board side: drives requests and the line level.
    modport master (
        output tick, send, line_in,
        input  line_oe, tx_busy, rx_strobe, rx_err, collision
    );

    // Transceiver side.
    modport slave (
        input  tick, send, line_in,
        output line_oe, tx_busy, rx_strobe, rx_err, collision
    );
endinterface

// File: rtl/ball_link_line_sync.sv
// line_sync: N-flop synchroniser for an asynchronous level that idles high.
//   clk, rst - clock, asynchronous active-high reset
//   i_d      - asynchronous input
//   o_q      - synchronised output (N clk latency)
// Flops reset to 1 so a reset never looks like a falling line edge.
module line_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [N-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];
endmodule

// File: rtl/ball_link.sv
// ball_link: single-wire ball-handoff transceiver.
//   clk, rst        - clock, asynchronous active-high reset
//   bus (slave)     - tick/send/line_in in; line_oe/tx_busy/rx_strobe/
//                     rx_err/collision out (see ball_link_if)
//   o_dbg_tx_state  - current TX FSM state
//   o_dbg_rx_state  - current RX FSM state
// TX turns a one-clk send into a TX_LEN-tick low pulse followed by a
// GUARD-tick recovery. RX synchronises line_in and reports low pulses whose
// width lies in [RX_MIN, RX_MAX] ticks; longer lows raise rx_err once.
// Optional macro BALL_LINK_COLLISION_EN: reject a send while the line is low
// or RX is busy, pulsing collision instead of driving.
module ball_link
    import ball_link_pkg::*;
#(
    parameter int TX_LEN = TX_LEN_DEF,
    parameter int GUARD  = GUARD_DEF,
    parameter int RX_MIN = RX_MIN_DEF,
    parameter int RX_MAX = RX_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    ball_link_if.slave  bus,
    output tx_state_t   o_dbg_tx_state,
    output rx_state_t   o_dbg_rx_state
);
    localparam int TCNT_W = $clog2(TX_LEN + GUARD + 1);
    localparam int RCNT_W = $clog2(RX_MAX + 2);

    localparam logic [TCNT_W-1:0] TX_LAST    = TCNT_W'(TX_LEN - 1);
    localparam logic [TCNT_W-1:0] GUARD_LAST = TCNT_W'(GUARD - 1);
    localparam logic [RCNT_W-1:0] RMIN       = RCNT_W'(RX_MIN);
    localparam logic [RCNT_W-1:0] RMAX       = RCNT_W'(RX_MAX);

    // ---------------- synchroniser ----------------
    logic w_s;

    line_sync #(.N(2)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.line_in),
        .o_q (w_s)
    );

    // ---------------- shared decode ----------------
    tx_state_t         r_tx_state, w_tx_next;
    logic [TCNT_W-1:0] r_tcnt, w_tcnt_next;
    rx_state_t         r_rx_state, w_rx_next;
    logic [RCNT_W-1:0] r_rcnt, w_rcnt_next;

    logic w_reject;
    logic w_tx_start;
    logic w_rx_blank;

`ifdef BALL_LINK_COLLISION_EN
    assign w_reject = bus.send && (r_tx_state == TX_IDLE) &&
                      ((r_rx_state != RX_IDLE) || !w_s);
`else
    assign w_reject = 1'b0;
`endif

    assign w_tx_start = bus.send && (r_tx_state == TX_IDLE) && !w_reject;

    // Blanking includes the accepting cycle so a send that coincides with a
    // falling line edge wins over RX.
    assign w_rx_blank = (r_tx_state != TX_IDLE) || w_tx_start;

    // ---------------- TX FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tcnt     <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            r_tcnt     <= w_tcnt_next;
        end
    end

    always_comb begin
        w_tx_next   = r_tx_state;
        w_tcnt_next = r_tcnt;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_tx_start) begin
                    w_tx_next   = TX_DRIVE;
                    w_tcnt_next = '0;
                end
            end
            TX_DRIVE: begin
                if (bus.tick) begin
                    if (r_tcnt == TX_LAST) begin
                        w_tx_next   = TX_RECOVER;
                        w_tcnt_next = '0;
                    end else begin
                        w_tcnt_next = r_tcnt + 1'b1;
                    end
                end
            end
            TX_RECOVER: begin
                if (bus.tick) begin
                    if (r_tcnt == GUARD_LAST) begin
                        w_tx_next   = TX_IDLE;
                        w_tcnt_next = '0;
                    end else begin
                        w_tcnt_next = r_tcnt + 1'b1;
                    end
                end
            end
            default: begin
                w_tx_next   = TX_IDLE;
                w_tcnt_next = '0;
            end
        endcase
    end

    // Decoded straight from the state flop so reset drops line_oe at once.
    always_comb begin
        bus.line_oe = (r_tx_state == TX_DRIVE);
        bus.tx_busy = (r_tx_state != TX_IDLE);
    end

    // ---------------- RX FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_rcnt     <= '0;
        end else begin
            r_rx_state <= w_rx_next;
            r_rcnt     <= w_rcnt_next;
        end
    end

    always_comb begin
        w_rx_next   = r_rx_state;
        w_rcnt_next = r_rcnt;
        if (w_rx_blank) begin
            w_rx_next   = RX_IDLE;
            w_rcnt_next = '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (!w_s) begin
                        w_rx_next   = RX_LOW;
                        w_rcnt_next = '0;
                    end
                end
                RX_LOW: begin
                    if (w_s) begin
                        w_rx_next   = RX_IDLE;
                        w_rcnt_next = '0;
                    end else if (bus.tick) begin
                        // Incrementing past RX_MAX means the line is stuck.
                        if (r_rcnt >= RMAX) begin
                            w_rx_next = RX_STUCK;
                        end else begin
                            w_rcnt_next = r_rcnt + 1'b1;
                        end
                    end
                end
                RX_STUCK: begin
                    if (w_s) begin
                        w_rx_next   = RX_IDLE;
                        w_rcnt_next = '0;
                    end
                end
                default: begin
                    w_rx_next   = RX_IDLE;
                    w_rcnt_next = '0;
                end
            endcase
        end
    end

    // Width is judged on the pre-increment count when tick and the rise
    // coincide, since r_rcnt is the registered value.
    always_comb begin
        bus.rx_strobe = !w_rx_blank && (r_rx_state == RX_LOW) && w_s &&
                        (r_rcnt >= RMIN) && (r_rcnt <= RMAX);
        bus.rx_err    = !w_rx_blank && (r_rx_state == RX_LOW) && !w_s &&
                        bus.tick && (r_rcnt >= RMAX);
        bus.collision = w_reject;
    end

    assign o_dbg_tx_state = r_tx_state;
    assign o_dbg_rx_state = r_rx_state;
endmodule
